// File: rtl/lpddr2_wt_cache.sv
// Direct-mapped, write-through, one-word-line cache between the CPU request port
// and the LPDDR2 Avalon bridge. Read hits complete locally; misses and writes go to the bridge.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FLUSH  | clearing one valid bit per cycle, index 0 .. 2^INDEX_BITS-1
// S_IDLE   | waiting for a CPU request or a pending flush
// S_LOOKUP | indexed line read, tag compared against the registered address
// S_MEM_RD | read miss outstanding on the bridge, line fill on mem_done
// S_MEM_WR | write-through outstanding on the bridge, hit line updated on mem_done
// S_RESP   | one-cycle cpu_ready pulse
module lpddr2_wt_cache #(
   parameter int ADDR_W     = 27,
   parameter int INDEX_BITS = 6
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              cpu_rreq,
   input  logic              cpu_wreq,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_busy,
   input  logic              flush,
   output logic              mem_rreq,
   output logic              mem_wreq,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_done,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS;

   typedef enum logic [2:0] {
      S_FLUSH,
      S_IDLE,
      S_LOOKUP,
      S_MEM_RD,
      S_MEM_WR,
      S_RESP
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0]     req_addr;
   logic [31:0]           req_wdata;
   logic                  req_write;
   logic                  req_hit;
   logic                  flush_pend;
   logic [INDEX_BITS-1:0] flush_idx;

   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic                  lookup_hit;
   logic                  fill;
   logic                  wr_upd;

   assign idx        = req_addr[INDEX_BITS-1:0];
   assign tag        = req_addr[ADDR_W-1:INDEX_BITS];
   assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);
   assign fill       = (state == S_MEM_RD) && mem_done;
   assign wr_upd     = (state == S_MEM_WR) && mem_done && req_hit;

   assign cpu_busy   = (state != S_IDLE);
   assign cpu_ready  = (state == S_RESP);

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) state <= S_FLUSH;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FLUSH:  if (flush_idx == INDEX_BITS'(LINES - 1)) state_nxt = S_IDLE;
         S_IDLE: begin
            if (flush_pend || flush)       state_nxt = S_FLUSH;
            else if (cpu_rreq || cpu_wreq) state_nxt = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (req_write)       state_nxt = S_MEM_WR;
            else if (lookup_hit) state_nxt = S_RESP;
            else                 state_nxt = S_MEM_RD;
         end
         S_MEM_RD: if (mem_done) state_nxt = S_RESP;
         S_MEM_WR: if (mem_done) state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         req_addr   <= '0;
         req_wdata  <= '0;
         req_write  <= 1'b0;
         req_hit    <= 1'b0;
         flush_pend <= 1'b0;
         flush_idx  <= '0;
         cpu_rdata  <= '0;
         mem_rreq   <= 1'b0;
         mem_wreq   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
      end else begin
         // A flush seen while busy is remembered and served on the next IDLE cycle.
         if (state != S_IDLE && flush) flush_pend <= 1'b1;

         case (state)
            S_FLUSH: flush_idx <= flush_idx + INDEX_BITS'(1);
            S_IDLE: begin
               if (flush_pend || flush) begin
                  flush_pend <= 1'b0;
               end else if (cpu_rreq || cpu_wreq) begin
                  req_addr  <= cpu_addr;
                  req_wdata <= cpu_wdata;
                  req_write <= cpu_wreq;
               end
            end
            S_LOOKUP: begin
               req_hit <= lookup_hit;
               if (req_write) begin
                  mem_wreq  <= 1'b1;
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
               end else if (lookup_hit) begin
                  cpu_rdata <= data_mem[idx];
                  if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
               end else begin
                  mem_rreq <= 1'b1;
                  mem_addr <= req_addr;
                  if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
               end
            end
            S_MEM_RD: begin
               if (mem_done) begin
                  mem_rreq  <= 1'b0;
                  cpu_rdata <= mem_rdata;
               end
            end
            S_MEM_WR: if (mem_done) mem_wreq <= 1'b0;
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; the FLUSH pass after reset clears every valid bit.
   always_ff @(posedge iCLK) begin
      if (state == S_FLUSH) valid[flush_idx] <= 1'b0;
      if (fill) begin
         valid[idx]    <= 1'b1;
         tag_mem[idx]  <= tag;
         data_mem[idx] <= mem_rdata;
      end
      if (wr_upd) data_mem[idx] <= req_wdata;
   end

endmodule

// File: tb/tb_lpddr2_wt_cache.sv
// Randomized self-checking bench for lpddr2_wt_cache with a line-level cache model
// and a behavioural bridge that serves reads and writes from its own memory.
module tb_lpddr2_wt_cache;

   localparam int AW = 27;

   logic          clk;
   logic          rst_n;
   logic          cpu_rreq;
   logic          cpu_wreq;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          cpu_ready;
   logic          cpu_busy;
   logic          flush;
   logic          mem_rreq;
   logic          mem_wreq;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_done;
   logic [15:0]   hit_cnt;
   logic [15:0]   miss_cnt;

   lpddr2_wt_cache #(.ADDR_W(AW), .INDEX_BITS(6)) dut (
      .iCLK      (clk),
      .iRST_n    (rst_n),
      .cpu_rreq  (cpu_rreq),
      .cpu_wreq  (cpu_wreq),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_busy  (cpu_busy),
      .flush     (flush),
      .mem_rreq  (mem_rreq),
      .mem_wreq  (mem_wreq),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_default(input logic [AW-1:0] a);
      return {5'h15, a} ^ 32'hC3A5_0F1E;
   endfunction

   // Reference model: the cache as a table of lines plus the memory contents
   logic          m_valid [64];
   logic [20:0]   m_tag   [64];
   logic [31:0]   m_data  [64];
   logic [15:0]   m_hit;
   logic [15:0]   m_miss;
   logic [31:0]   ref_mem [logic [AW-1:0]];

   function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_hit  = '0;
      m_miss = '0;
   endtask

   task automatic model_flush();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   // Behavioural bridge
   logic [31:0]   bridge_mem [logic [AW-1:0]];
   int            br_lat    = -1;
   int            br_n_rd   = 0;
   int            br_n_wr   = 0;
   int            br_n_both = 0;
   logic          br_wr;
   logic [AW-1:0] br_addr;
   logic [31:0]   br_wdata;
   int            br_cur_lat;
   bit            br_abort;

   initial begin
      mem_done  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && (mem_rreq || mem_wreq)) begin
            br_wr    = mem_wreq;
            br_addr  = mem_addr;
            br_wdata = mem_wdata;
            if (mem_rreq && mem_wreq) br_n_both++;
            if (br_wr) br_n_wr++;
            else       br_n_rd++;
            br_cur_lat = (br_lat >= 0) ? br_lat : int'($urandom_range(0, 5));
            br_abort   = 1'b0;
            for (int i = 0; i < br_cur_lat && !br_abort; i++) begin
               @(negedge clk);
               if (!rst_n) begin
                  br_abort = 1'b1;
               end else begin
                  check_eq("mem_req_hold", {31'b0, br_wr ? mem_wreq : mem_rreq}, 32'd1);
                  check_eq("mem_addr_hold", 32'(mem_addr), 32'(br_addr));
                  if (br_wr) check_eq("mem_wdata_hold", mem_wdata, br_wdata);
               end
            end
            if (!br_abort) begin
               if (br_wr) bridge_mem[br_addr] = br_wdata;
               else mem_rdata = bridge_mem.exists(br_addr) ? bridge_mem[br_addr] : mem_default(br_addr);
               mem_done = 1'b1;
               @(negedge clk);
               mem_done  = 1'b0;
               mem_rdata = $urandom;
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (cpu_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (cpu_busy) check_eq("idle_timeout", {31'b0, cpu_busy}, 32'd0);
   endtask

   task automatic do_op(input bit is_wr, input bit both, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input bit flush_in_rd);
      int          rd0, wr0, both0, cyc;
      bit          got, done_edge, pulsed, flushing, hit;
      logic [5:0]  ix;
      logic [20:0] tg;
      logic [31:0] exp_rd;
      wait_idle();
      ix    = addr[5:0];
      tg    = addr[26:6];
      hit   = m_valid[ix] && (m_tag[ix] == tg);
      rd0   = br_n_rd;
      wr0   = br_n_wr;
      both0 = br_n_both;
      cpu_rreq  = !is_wr || both;
      cpu_wreq  = is_wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_rreq  = 1'b0;
      cpu_wreq  = 1'b0;
      cpu_addr  = AW'($urandom);
      cpu_wdata = $urandom;
      cyc = 1; got = 0; pulsed = 0; flushing = 0; done_edge = 0;
      while (!got && cyc < 300) begin
         @(posedge clk);
         done_edge = mem_done;
         #1;
         cyc++;
         if (flushing) begin
            flush    = 1'b0;
            flushing = 1'b0;
         end
         if (flush_in_rd && !pulsed && mem_rreq) begin
            flush    = 1'b1;
            pulsed   = 1'b1;
            flushing = 1'b1;
         end
         if (cpu_ready) got = 1'b1;
      end
      flush = 1'b0;
      if (!got) begin
         check_eq("ready_timeout", 32'd0, 32'd1);
         return;
      end
      if (is_wr || !hit) check_eq("ready_after_done", {31'b0, done_edge}, 32'd1);
      else               check_eq("hit_latency", cyc, 32'd2);

      if (is_wr) begin
         ref_mem[addr] = wdata;
         if (hit) m_data[ix] = wdata;
         check_eq("mem_wr_count", br_n_wr - wr0, 32'd1);
         check_eq("mem_rd_count", br_n_rd - rd0, 32'd0);
         check_eq("mem_wr_addr", 32'(br_addr), 32'(addr));
         check_eq("mem_wr_data", br_wdata, wdata);
      end else begin
         if (hit) begin
            exp_rd = m_data[ix];
            if (m_hit != 16'hFFFF) m_hit++;
            check_eq("mem_rd_count", br_n_rd - rd0, 32'd0);
         end else begin
            exp_rd = ref_rd(addr);
            if (m_miss != 16'hFFFF) m_miss++;
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            m_data[ix]  = exp_rd;
            check_eq("mem_rd_count", br_n_rd - rd0, 32'd1);
            check_eq("mem_rd_addr", 32'(br_addr), 32'(addr));
         end
         check_eq("mem_wr_count", br_n_wr - wr0, 32'd0);
         check_eq("cpu_rdata", cpu_rdata, exp_rd);
      end
      check_eq("both_req", br_n_both - both0, 32'd0);
      check_eq("hit_cnt", 32'(hit_cnt), 32'(m_hit));
      check_eq("miss_cnt", 32'(miss_cnt), 32'(m_miss));
      @(posedge clk);
      #1;
      check_eq("ready_pulse", {31'b0, cpu_ready}, 32'd0);
   endtask

   task automatic count_busy(input string tag, input int window, input int exp);
      int ones;
      ones = 0;
      for (int i = 0; i < window; i++) begin
         @(posedge clk);
         #1;
         if (cpu_busy) ones++;
      end
      check_eq(tag, ones, exp);
      check_eq({tag, "_end"}, {31'b0, cpu_busy}, 32'd0);
   endtask

   task automatic do_flush();
      wait_idle();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_busy_start", {31'b0, cpu_busy}, 32'd1);
      count_busy("flush_busy_len", 70, 63);
      model_flush();
   endtask

   task automatic wait_reset_flush(input string tag);
      int e;
      e = 0;
      while (e < 100) begin
         @(posedge clk);
         #1;
         e++;
         if (!cpu_busy) break;
      end
      check_eq(tag, e, 32'd64);
   endtask

   logic [AW-1:0] ra;
   int            rr;
   int            wn;

   initial begin
      rst_n     = 1'b0;
      cpu_rreq  = 1'b0;
      cpu_wreq  = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      flush     = 1'b0;
      model_reset();
      ref_mem[27'h123]    = 32'hDEADBEEF;
      bridge_mem[27'h123] = 32'hDEADBEEF;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", {31'b0, cpu_busy}, 32'd1);
      check_eq("rst_ready", {31'b0, cpu_ready}, 32'd0);
      check_eq("rst_rdata", cpu_rdata, 32'd0);
      check_eq("rst_mem_req", {30'b0, mem_rreq, mem_wreq}, 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      check_eq("rst_counters", {hit_cnt, miss_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_reset_flush("reset_flush_len");

      br_lat = 5;
      do_op(0, 0, 27'h123, '0, 0);
      do_op(0, 0, 27'h123, '0, 0);
      br_lat = -1;
      do_op(1, 0, 27'h123, 32'h0BADF00D, 0);
      do_op(0, 0, 27'h123, '0, 0);
      check_eq("write_hit_read", cpu_rdata, 32'h0BADF00D);

      do_op(0, 0, 27'h040, '0, 0);
      do_op(0, 0, 27'h080, '0, 0);
      do_op(0, 0, 27'h080, '0, 0);

      // Flush raised while a fill is outstanding: the fill still completes, then every line goes
      br_lat = 5;
      do_op(0, 0, 27'h0C0, '0, 1);
      br_lat = -1;
      count_busy("deferred_flush_len", 70, 64);
      model_flush();
      do_op(0, 0, 27'h123, '0, 0);

      do_op(1, 1, 27'h0155, 32'h1234_5678, 0);
      do_op(1, 1, 27'h123, 32'hCAFE_0001, 0);
      do_op(0, 0, 27'h123, '0, 0);

      for (int k = 0; k < 150; k++) begin
         ra = AW'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
         rr = $urandom_range(0, 99);
         if (rr < 3)       do_flush();
         else if (rr < 8)  do_op(1, 1, ra, $urandom, 0);
         else if (rr < 35) do_op(1, 0, ra, $urandom, 0);
         else              do_op(0, 0, ra, '0, 0);
      end

      do_flush();

      // Saturation: start the hit counter just below the top and keep hitting
      do_op(0, 0, 27'h0777, '0, 0);
      wait_idle();
      force dut.hit_cnt = 16'hFFFC;
      #1;
      release dut.hit_cnt;
      m_hit = 16'hFFFC;
      for (int k = 0; k < 5; k++) do_op(0, 0, 27'h0777, '0, 0);
      check_eq("hit_saturated", 32'(hit_cnt), 32'h0000FFFF);

      // Reset while a read miss is outstanding on the bridge
      wait_idle();
      br_lat   = 30;
      cpu_rreq = 1'b1;
      cpu_addr = 27'h3F_F00A;
      @(posedge clk);
      #1;
      cpu_rreq = 1'b0;
      wn = 0;
      while (!mem_rreq && wn < 20) begin
         @(posedge clk);
         #1;
         wn++;
      end
      check_eq("midrst_rreq_seen", {31'b0, mem_rreq}, 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_req_drop", {30'b0, mem_rreq, mem_wreq}, 32'd0);
      check_eq("midrst_ready", {31'b0, cpu_ready}, 32'd0);
      check_eq("midrst_busy", {31'b0, cpu_busy}, 32'd1);
      check_eq("midrst_counters", {hit_cnt, miss_cnt}, 32'd0);
      repeat (3) @(negedge clk);
      check_eq("midrst_no_ready", {31'b0, cpu_ready}, 32'd0);
      rst_n  = 1'b1;
      br_lat = -1;
      model_reset();
      wait_reset_flush("midrst_flush_len");
      do_op(0, 0, 27'h3F_F00A, '0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
